// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA demo sequencer.
package vga_seq_pkg;

  // Sequencer states; encoding 3 is never entered on purpose and recovers to S_TP.
  typedef enum logic [1:0] {
    S_TP    = 2'd0,
    S_DEMO  = 2'd1,
    S_GAP   = 2'd2,
    S_BAD   = 2'd3
  } seq_state_e;

  // Galois feedback taps for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // One LFSR step; an all-zero register would lock up, so it reloads the seed instead.
  function automatic logic [31:0] lfsr_next(input logic [31:0] r, input logic [31:0] seed);
    if (r == 32'd0) begin
      return seed;
    end
    return (r >> 1) ^ (r[0] ? LFSR_MASK : 32'd0);
  endfunction

endpackage

// File: rtl/vga_demo_sequencer_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 400000
) (
  input  logic clk_dot,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_evt
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The debounced level only follows the synchronized input after it has disagreed for DEB_CYCLES clocks in a row.
  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    evt_d    = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        evt_d    = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register the synchronizer, counter, debounced level and press pulse.
  always_ff @(posedge clk_dot) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      evt_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      evt_q    <= evt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign btn_evt = evt_q;

endmodule

// File: rtl/vga_demo_sequencer.sv
// Frame-synchronous controller for vga_core: schedules test pattern, demos and
// re-arm gaps on mode_bit/color_3b, and supplies the random_num seed word.
module vga_demo_sequencer
  import vga_seq_pkg::*;
#(
  parameter int unsigned TP_FRAMES       = 120,
  parameter int unsigned DEMO_FRAMES     = 600,
  parameter int unsigned GAP_FRAMES      = 2,
  parameter int unsigned DEMOS_PER_CYCLE = 4,
  parameter logic        VSYNC_POL       = 1'b0,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
  parameter int unsigned DEB_CYCLES      = 400000
) (
  input  logic        clk_dot,
  input  logic        reset_n,
  input  logic        vga_vsync,
  input  logic        auto_en,
  input  logic        btn_next,
  output logic        mode_bit,
  output logic        color_3b,
  output logic [31:0] random_num,
  output logic [1:0]  seq_state,
  output logic [2:0]  demo_idx
);

  localparam logic [15:0] TP_LAST   = 16'(TP_FRAMES - 1);
  localparam logic [15:0] DEMO_LAST = 16'(DEMO_FRAMES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_FRAMES - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(DEMOS_PER_CYCLE - 1);

  logic        vsync_d1_q, vsync_d2_q;
  logic        frame_tick;
  logic        btn_evt;

  seq_state_e  state_q, state_d;
  logic        mode_q, mode_d;
  logic        color_q, color_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]  demo_idx_q, demo_idx_d;
  logic        pend_q, pend_d;
  logic [31:0] lfsr_q, lfsr_d;

  logic [15:0] limit_last;
  logic        rise_ok;
  logic        advance;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk_dot (clk_dot),
    .reset_n (reset_n),
    .btn_in  (btn_next),
    .btn_evt (btn_evt)
  );

  // Keep two registered copies of vsync so the frame tick is a clean one-clock pulse after the edge.
  always_ff @(posedge clk_dot) begin
    if (!reset_n) begin
      vsync_d1_q <= ~VSYNC_POL;
      vsync_d2_q <= ~VSYNC_POL;
    end else begin
      vsync_d1_q <= vga_vsync;
      vsync_d2_q <= vsync_d1_q;
    end
  end

  assign frame_tick = (vsync_d1_q == VSYNC_POL) && (vsync_d2_q != VSYNC_POL);

  // Decide whether this frame ends the current state; rising mode_bit waits until the low time covers GAP_FRAMES.
  always_comb begin
    case (state_q)
      S_TP:    limit_last = TP_LAST;
      S_DEMO:  limit_last = DEMO_LAST;
      default: limit_last = GAP_LAST;
    endcase
    rise_ok = (state_q == S_DEMO) || (frame_cnt_q >= GAP_LAST);
    advance = ((auto_en && (frame_cnt_q == limit_last)) || pend_q) && rise_ok;
  end

  // Next-state logic for the schedule; everything moves only on a frame tick except illegal-state recovery.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    color_d     = color_q;
    frame_cnt_d = frame_cnt_q;
    demo_idx_d  = demo_idx_q;
    pend_d      = pend_q | btn_evt;
    if (frame_tick) begin
      if (advance) begin
        frame_cnt_d = '0;
        pend_d      = btn_evt;
        case (state_q)
          S_TP: begin
            state_d = S_DEMO;
            mode_d  = 1'b1;
          end
          S_DEMO: begin
            mode_d = 1'b0;
            if (demo_idx_q >= IDX_LAST) begin
              state_d    = S_TP;
              demo_idx_d = '0;
              color_d    = ~color_q;
            end else begin
              state_d    = S_GAP;
              demo_idx_d = demo_idx_q + 3'd1;
            end
          end
          S_GAP: begin
            state_d = S_DEMO;
            mode_d  = 1'b1;
          end
          default: ;
        endcase
      end else if (frame_cnt_q != 16'hFFFF) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
    if (state_q == S_BAD) begin
      state_d     = S_TP;
      mode_d      = 1'b0;
      frame_cnt_d = '0;
      demo_idx_d  = '0;
      pend_d      = 1'b0;
    end
  end

  // Sequencer state register with registered outputs.
  always_ff @(posedge clk_dot) begin
    if (!reset_n) begin
      state_q     <= S_TP;
      mode_q      <= 1'b0;
      color_q     <= 1'b0;
      frame_cnt_q <= '0;
      demo_idx_q  <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      color_q     <= color_d;
      frame_cnt_q <= frame_cnt_d;
      demo_idx_q  <= demo_idx_d;
      pend_q      <= pend_d;
    end
  end

  // Free-running LFSR next value, independent of the schedule.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q, LFSR_SEED);
  end

  // LFSR register; reset loads the seed so vga_core sees a repeatable sequence.
  always_ff @(posedge clk_dot) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign mode_bit   = mode_q;
  assign color_3b   = color_q;
  assign random_num = lfsr_q;
  assign seq_state  = state_q;
  assign demo_idx   = demo_idx_q;

endmodule

// File: tb/tb_vga_demo_sequencer.sv
// Self-checking bench for vga_demo_sequencer with shrunk frame counts and a
// 100-clock synthetic vsync.
module tb_vga_demo_sequencer;

  localparam int unsigned TP    = 2;
  localparam int unsigned DEMO  = 3;
  localparam int unsigned GAP   = 1;
  localparam int unsigned DPC   = 2;
  localparam int unsigned DEB   = 4;
  localparam logic [31:0] SEED  = 32'hACE1_2468;
  localparam logic [31:0] TAPS  = 32'h8020_0003;

  typedef struct {
    logic       auto_en;
    logic       press;
    logic [1:0] state;
    logic       mode;
    logic       color;
    logic [2:0] idx;
  } vec_t;

  logic        clk_dot;
  logic        reset_n;
  logic        vga_vsync;
  logic        auto_en;
  logic        btn_next;
  logic        mode_bit;
  logic        color_3b;
  logic [31:0] random_num;
  logic [1:0]  seq_state;
  logic [2:0]  demo_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 50;

  logic mon_en = 1'b0;
  logic mon_last_mode = 1'b0;
  logic mon_last_rstn = 1'b0;
  int   mon_low_frames = 0;

  vec_t vecs[18];

  vga_demo_sequencer #(
    .TP_FRAMES       (TP),
    .DEMO_FRAMES     (DEMO),
    .GAP_FRAMES      (GAP),
    .DEMOS_PER_CYCLE (DPC),
    .VSYNC_POL       (1'b0),
    .LFSR_SEED       (SEED),
    .DEB_CYCLES      (DEB)
  ) dut (
    .clk_dot    (clk_dot),
    .reset_n    (reset_n),
    .vga_vsync  (vga_vsync),
    .auto_en    (auto_en),
    .btn_next   (btn_next),
    .mode_bit   (mode_bit),
    .color_3b   (color_3b),
    .random_num (random_num),
    .seq_state  (seq_state),
    .demo_idx   (demo_idx)
  );

  // 10 ns dot clock.
  initial clk_dot = 1'b0;
  always #5 clk_dot = ~clk_dot;

  // Synthetic vsync: active-low for 10 of every 100 clocks, entering the active level when vcnt wraps to 0.
  initial vga_vsync = 1'b1;
  always @(negedge clk_dot) begin
    vcnt = (vcnt == 99) ? 0 : vcnt + 1;
    vga_vsync = (vcnt < 10) ? 1'b0 : 1'b1;
  end

  // Reference LFSR step written from the polynomial description.
  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    if (r == 32'd0) return SEED;
    return {1'b0, r[31:1]} ^ (r[0] ? TAPS : 32'd0);
  endfunction

  function automatic logic [31:0] pk(input logic [1:0] s, input logic m, input logic c, input logic [2:0] i);
    return {25'd0, s, m, c, i};
  endfunction

  task automatic step();
    @(negedge clk_dot);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Waits until the sequencer has had time to act on the next frame tick (two clocks after vsync goes active).
  task automatic waitTick();
    for (int k = 0; k < 300; k++) begin
      step();
      if (vcnt == 2) return;
    end
    checkOutput("tick timeout", 32'd1, 32'd0);
  endtask

  task automatic waitVcnt(input int target);
    for (int k = 0; k < 300; k++) begin
      step();
      if (vcnt == target) return;
    end
    checkOutput("vcnt timeout", 32'd1, 32'd0);
  endtask

  task automatic pressButton(input int len);
    btn_next = 1'b1;
    repeat (len) step();
    btn_next = 1'b0;
    repeat (DEB + 4) step();
  endtask

  // Reset is applied mid-frame so release never lands while vsync is active.
  task automatic doReset(input int len);
    waitVcnt(50);
    reset_n = 1'b0;
    repeat (len) step();
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    auto_en = v.auto_en;
    if (v.press) pressButton(10);
    waitTick();
  endtask

  // Property monitor: mode_bit only moves right after a frame tick (or reset), stays low at least GAP frames, and state 3 never shows.
  always @(negedge clk_dot) begin
    #2;
    if (mon_en) begin
      n_checks++;
      if (seq_state == 2'd3) begin
        n_fail++;
        $display("[TB] FAIL state legal: got %0d, expected 0..2", seq_state);
      end
      if (mode_bit != mon_last_mode) begin
        n_checks++;
        if (!(vcnt == 2 || !mon_last_rstn)) begin
          n_fail++;
          $display("[TB] FAIL mode edge timing: edge at vcnt %0d, expected vcnt 2", vcnt);
        end
        if (mode_bit) begin
          n_checks++;
          if (mon_low_frames < GAP) begin
            n_fail++;
            $display("[TB] FAIL mode low time: got %0d frames, expected >= %0d", mon_low_frames, GAP);
          end
        end
        mon_low_frames = 0;
      end
      if (!mode_bit && vcnt == 0) mon_low_frames++;
    end
    mon_last_mode = mode_bit;
    mon_last_rstn = reset_n;
  end

  initial begin
    logic [31:0] model;

    // Per-frame schedule: auto run through a full cycle, then button-driven steps, then auto again.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 3'd1};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd1};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd1};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 3'd0};
    vecs[12] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 3'd0};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 3'd1};
    vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 3'd1};
    vecs[15] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0};
    vecs[16] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    vecs[17] = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0};

    reset_n  = 1'b0;
    auto_en  = 1'b1;
    btn_next = 1'b0;
    repeat (3) step();
    checkOutput("reset outputs", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd0, 1'b0, 1'b0, 3'd0));
    checkOutput("reset random_num", random_num, SEED);
    mon_en = 1'b1;

    // LFSR sequence from reset release.
    reset_n = 1'b1;
    model = SEED;
    for (int i = 0; i < 6; i++) begin
      step();
      model = lfsr_step(model);
      checkOutput($sformatf("lfsr step %0d", i + 1), random_num, model);
    end

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec %0d", i), pk(seq_state, mode_bit, color_3b, demo_idx),
                  pk(vecs[i].state, vecs[i].mode, vecs[i].color, vecs[i].idx));
    end

    // Lockup guard: an all-zero register must produce the seed as its next value.
    step();
    force dut.lfsr_q = 32'd0;
    #1;
    checkOutput("lfsr zero reload", dut.lfsr_d, lfsr_step(32'd0));
    release dut.lfsr_q;

    // Manual mode with no button: the schedule must hold in test pattern.
    auto_en = 1'b0;
    doReset(2);
    for (int i = 0; i < 20; i++) begin
      waitTick();
      checkOutput($sformatf("idle frame %0d", i), pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd0, 1'b0, 1'b0, 3'd0));
    end
    pressButton(10);
    waitTick();
    checkOutput("button advance", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd1, 1'b1, 1'b0, 3'd0));
    waitTick();
    checkOutput("button advance once", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd1, 1'b1, 1'b0, 3'd0));

    // Glitches, collapsed double press, and a press that lands on the frame tick.
    doReset(2);
    waitTick();
    repeat (4) begin
      btn_next = 1'b1;
      step();
      btn_next = 1'b0;
      repeat (3) step();
    end
    waitTick();
    checkOutput("glitch ignored", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd0, 1'b0, 1'b0, 3'd0));
    pressButton(10);
    pressButton(10);
    waitTick();
    checkOutput("double press advance", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd1, 1'b1, 1'b0, 3'd0));
    waitTick();
    checkOutput("double press single", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd1, 1'b1, 1'b0, 3'd0));
    // Two sync flops plus DEB stable clocks put the debounced pulse on the same clock as the frame tick.
    waitVcnt(95);
    btn_next = 1'b1;
    waitTick();
    checkOutput("coincident press held", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd1, 1'b1, 1'b0, 3'd0));
    repeat (4) step();
    btn_next = 1'b0;
    waitTick();
    checkOutput("coincident press later", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd2, 1'b0, 1'b0, 3'd1));

    // One-clock reset in the middle of the second demo of the second cycle.
    auto_en = 1'b1;
    doReset(2);
    repeat (15) waitTick();
    checkOutput("pre-reset demo", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd1, 1'b1, 1'b1, 3'd1));
    waitVcnt(50);
    reset_n = 1'b0;
    step();
    checkOutput("mid reset outputs", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd0, 1'b0, 1'b0, 3'd0));
    checkOutput("mid reset random_num", random_num, SEED);
    reset_n = 1'b1;
    waitTick();
    checkOutput("post reset tp", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd0, 1'b0, 1'b0, 3'd0));
    waitTick();
    checkOutput("post reset demo", pk(seq_state, mode_bit, color_3b, demo_idx), pk(2'd1, 1'b1, 1'b0, 3'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
